// File: rtl/vib_event_counter_mc.sv
// vib_event_counter_mc -- multi-channel vibration/pulse event counter.
// Each channel: 2-FF synchroniser, run-time bypassable debounce, rising-edge
// detect, saturating BCD total and BCD events-per-window rate.
// The selected channel's total or rate is presented as packed BCD on o_data.
// Optional feature macro: VIB_PEAK_HOLD_EN (per-channel peak-rate hold shown
// in rate mode instead of the last window's rate).
module vib_event_counter_mc #(
    parameter int CH_NUM     = 4,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int WIN_CYCLES = 50000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CH_NUM-1:0]     i_sense,
    input  logic                  i_raw,
    input  logic [2:0]            i_ch_sel,
    input  logic                  i_mode,
    input  logic                  i_clr,
    output logic [4*DIGITS-1:0]   o_data,
    output logic [CH_NUM-1:0]     o_event,
    output logic [CH_NUM-1:0]     o_ovf
);

    localparam int W   = 4 * DIGITS;
    localparam int DCW = $clog2(DEB_CYCLES);
    localparam int WCW = $clog2(WIN_CYCLES);
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

    // BCD increment with per-digit carry 9 -> 0
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sat_inc(input logic [W-1:0] v);
        return (v == ALL9) ? v : bcd_inc(v);
    endfunction

    logic [WCW-1:0] win_q, win_d;
    logic           win_wrap;
    logic [W-1:0]   total_arr [CH_NUM];
    logic [W-1:0]   disp_arr  [CH_NUM];
    logic [W-1:0]   data_q, data_d;

    assign win_wrap = (win_q == WCW'(WIN_CYCLES - 1));

    // Shared rate window counter, 0..WIN_CYCLES-1
    always_comb begin
        win_d = win_q + 1'b1;
        if (win_wrap) win_d = '0;
    end

    // Window counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) win_q <= '0;
        else       win_q <= win_d;
    end

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        logic           s1_q, s2_q;
        logic           f_q, f_d;
        logic [DCW-1:0] deb_q, deb_d;
        logic           lvl, lvl_q;
        logic           ev_q, ev_d;
        logic           clr_hit;
        logic [W-1:0]   total_q, total_d;
        logic [W-1:0]   acc_q, acc_d, acc_ev;
        logic [W-1:0]   rate_q, rate_d;
        logic           ovf_q, ovf_d;
`ifdef VIB_PEAK_HOLD_EN
        logic [W-1:0]   peak_q, peak_d;
`endif

        // A clear addressed to an out-of-range channel matches no channel
        assign clr_hit = i_clr && (i_ch_sel == 3'(n));
        assign lvl     = i_raw ? s2_q : f_q;
        assign ev_d    = lvl & ~lvl_q;

        // Debounce: accept a level change after DEB_CYCLES mismatched cycles
        always_comb begin
            f_d   = f_q;
            deb_d = '0;
            if (s2_q != f_q) begin
                if (deb_q == DCW'(DEB_CYCLES - 1)) begin
                    f_d = s2_q;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        end

        // Total, rate accumulator, rate latch and overflow; clear has priority
        always_comb begin
            total_d = total_q;
            ovf_d   = ovf_q;
            rate_d  = rate_q;
            acc_ev  = ev_q ? bcd_sat_inc(acc_q) : acc_q;
            acc_d   = acc_ev;
`ifdef VIB_PEAK_HOLD_EN
            peak_d  = peak_q;
`endif
            if (ev_q) begin
                if (total_q == ALL9) ovf_d   = 1'b1;
                else                 total_d = bcd_inc(total_q);
            end
            if (win_wrap) begin
                rate_d = acc_ev;
                acc_d  = '0;
`ifdef VIB_PEAK_HOLD_EN
                // Packed BCD orders the same as its decimal magnitude
                if (acc_ev > peak_q) peak_d = acc_ev;
`endif
            end
            if (clr_hit) begin
                total_d = '0;
                ovf_d   = 1'b0;
                rate_d  = '0;
                acc_d   = '0;
`ifdef VIB_PEAK_HOLD_EN
                peak_d  = '0;
`endif
            end
        end

        // Per-channel state registers
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                f_q     <= 1'b0;
                deb_q   <= '0;
                lvl_q   <= 1'b0;
                ev_q    <= 1'b0;
                total_q <= '0;
                acc_q   <= '0;
                rate_q  <= '0;
                ovf_q   <= 1'b0;
`ifdef VIB_PEAK_HOLD_EN
                peak_q  <= '0;
`endif
            end else begin
                s1_q    <= i_sense[n];
                s2_q    <= s1_q;
                f_q     <= f_d;
                deb_q   <= deb_d;
                lvl_q   <= lvl;
                ev_q    <= ev_d;
                total_q <= total_d;
                acc_q   <= acc_d;
                rate_q  <= rate_d;
                ovf_q   <= ovf_d;
`ifdef VIB_PEAK_HOLD_EN
                peak_q  <= peak_d;
`endif
            end
        end

        assign o_event[n]   = ev_q;
        assign o_ovf[n]     = ovf_q;
        assign total_arr[n] = total_q;
`ifdef VIB_PEAK_HOLD_EN
        assign disp_arr[n]  = peak_q;
`else
        assign disp_arr[n]  = rate_q;
`endif
    end

    // Display mux; unmatched selects fall through to zero
    always_comb begin
        data_d = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (i_ch_sel == 3'(n)) data_d = i_mode ? disp_arr[n] : total_arr[n];
        end
    end

    // Registered display output
    always_ff @(posedge i_clk) begin
        if (i_rst) data_q <= '0;
        else       data_q <= data_d;
    end

    assign o_data = data_q;

endmodule

// File: doc/vib_event_counter_mc.md
Name: vib_event_counter_mc

Overview:
- Multi-channel vibration/pulse event counter, parametrised successor to the single-channel vibration demo.
- Per channel:
  - 2-FF synchroniser
  - debounce filter, bypassable at run time
  - rising-edge event detect
  - saturating BCD total counter
  - BCD events-per-window rate measurement
- Selected channel's value goes out as packed BCD for the existing 4-digit seg_drive.

Parameters:
- CH_NUM, 4, number of sensor channels (1..8).
- DIGITS, 4, BCD digits per counter; o_data width is 4*DIGITS.
- DEB_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms @ 50 MHz); minimum 2.
- WIN_CYCLES, 50000000, rate window length in cycles (1 s @ 50 MHz); minimum 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sense  in  CH_NUM  raw asynchronous sensor inputs, active high.
- i_raw  in  1  1 = bypass debounce (synchronised input used directly), 0 = debounced.
- i_ch_sel  in  3  channel shown on o_data; values >= CH_NUM show all zeros.
- i_mode  in  1  0 = total count, 1 = rate.
- i_clr  in  1  single-cycle pulse: clears total, rate and ovf of the selected channel.
- o_data  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- o_event  out  CH_NUM  one-cycle pulse per accepted rising edge.
- o_ovf  out  CH_NUM  sticky: total counter saturated.

Behaviour:
- Reset: a synchronous reset zeroes all state on the next i_clk edge while i_rst = 1. This covers:
  - synchronisers and debounce counters
  - filtered levels, totals, rate accumulators and rate registers
  - window counter
  - o_data, o_event and o_ovf
- Reset mid-window discards the partial window.
- Synchroniser: two flops per channel; output s[n].
- Debounce:
  - Filtered level f[n] and counter d[n].
  - If s[n] == f[n]: d[n] is cleared.
  - Otherwise d[n] increments. When d[n] reaches DEB_CYCLES-1 while still mismatched, f[n] takes s[n] and d[n] is cleared.
  - Any glitch shorter than DEB_CYCLES cycles produces no change.
- Level source: lvl[n] = i_raw ? s[n] : f[n].
- Edge detect:
  - o_event[n] = lvl[n] & ~lvl_d[n], registered.
  - Latency from i_sense rising, with i_raw = 1: 3 cycles.
  - With i_raw = 0: 2 + DEB_CYCLES + 1 cycles.
  - Toggling i_raw may produce one spurious event; this is accepted.
- Total counter:
  - BCD, DIGITS digits, increments on o_event[n] with per-digit carry 9 to 0.
  - At all-9s it holds, and o_ovf[n] is set and stays set until clear or reset.
- Rate:
  - Window counter runs 0..WIN_CYCLES-1 and wraps.
  - On the wrap cycle, each channel's rate register takes its accumulator (plus an event in that cycle, saturating). The accumulator then restarts at 0.
  - An event in the cycle after wrap counts in the new window.
  - The accumulator saturates at all-9s without a flag.
- Clear:
  - i_clr clears the selected channel's total, accumulator, rate register and ovf.
  - Clear wins over a simultaneous event or window latch on that channel.
  - Other channels are unaffected.
  - i_clr with i_ch_sel >= CH_NUM is ignored.
- Output:
  - o_data is registered, 1-cycle latency from i_ch_sel / i_mode / counter change.
  - It shows total[sel] when i_mode = 0, and the displayed rate value when i_mode = 1.
- Simultaneous events on different channels are all counted in the same cycle.

Optional Feature:
- Macro: VIB_PEAK_HOLD_EN.
- Defined:
  - Each channel keeps a peak-rate register, updated at window wrap with max(peak, new rate) by BCD magnitude compare.
  - i_mode = 1 displays the peak.
  - Peak is cleared by i_clr or reset.
- Not defined:
  - No peak registers are built.
  - i_mode = 1 displays the last completed window's rate.

Test Plan (bench params CH_NUM = 4, DIGITS = 4, DEB_CYCLES = 4, WIN_CYCLES = 100):
- Reset: hold i_rst for 3 cycles with random i_sense -> o_data = 0x0000, o_event = 0, o_ovf = 0. Then apply i_raw = 1 and a ch0 rising edge -> o_event[0] pulses exactly 3 cycles later.
- Debounce: i_raw = 0, ch1 high-pulses of 3 cycles then one of 6 cycles -> exactly one o_event[1]. With i_ch_sel = 1, i_mode = 0 -> o_data = 0x0001.
- Carry and saturation:
  - 10 events on ch2 -> o_data = 0x0010.
  - Preload via 9999 events -> 0x9999 with o_ovf[2] = 0.
  - One more event -> still 0x9999 and o_ovf[2] = 1.
- Rate and wrap: 7 ch0 events in window 1, the 7th on the wrap cycle, then 2 events in window 2 -> i_mode = 1 shows 0x0007 after the first wrap, then 0x0002 after the second. Without the macro, a third empty window shows 0x0000.
- Clear priority: i_clr with i_ch_sel = 2 in the same cycle as a ch2 event and a ch3 event -> total[2] = 0x0000, o_ovf[2] = 0, total[3] increments by 1.
- VIB_PEAK_HOLD_EN: windows with 5, 12 and 3 events on ch0 -> i_mode = 1 reads 0x0005, 0x0012, 0x0012. i_clr then gives 0x0000.
